// File: rtl/target_load_ctrl_if.sv
// -----------------------------------------------------------------------------
// target_load_ctrl_if
//   Bundles the signals between target_load_ctrl and its neighbours:
//   - compact-word handshake (bits_valid / bits_ready / bits)
//   - committed-target publication (target, target_valid, target_update)
//   - status (busy, err_invalid) and an FSM state debug view (fsm_state)
//   - hash comparison channel (hash_valid / hash -> hit_valid / hit)
//
//   Handshake rule for the compact word: a transfer happens on a rising clk
//   edge where bits_valid && bits_ready are both 1. The producer keeps bits
//   stable and bits_valid asserted until that edge; bits_ready never depends
//   on bits_valid. The hash channel has no back-pressure: every cycle with
//   hash_valid=1 yields a hit_valid/hit result one cycle later.
//
//   Modports:
//     slave  - the target_load_ctrl side
//     master - the environment side (header source + hashing cores)
// -----------------------------------------------------------------------------
interface target_load_ctrl_if;
  logic         bits_valid;
  logic         bits_ready;
  logic [31:0]  bits;
  logic         busy;
  logic [255:0] target;
  logic         target_valid;
  logic         target_update;
  logic         err_invalid;
  logic         hash_valid;
  logic [255:0] hash;
  logic         hit_valid;
  logic         hit;
  // Debug view of the expansion FSM: 0=IDLE 1=LOAD 2=SHIFT 3=COMMIT
  logic [1:0]   fsm_state;

  modport slave (
    input  bits_valid,
    input  bits,
    input  hash_valid,
    input  hash,
    output bits_ready,
    output busy,
    output target,
    output target_valid,
    output target_update,
    output err_invalid,
    output hit_valid,
    output hit,
    output fsm_state
  );

  modport master (
    output bits_valid,
    output bits,
    output hash_valid,
    output hash,
    input  bits_ready,
    input  busy,
    input  target,
    input  target_valid,
    input  target_update,
    input  err_invalid,
    input  hit_valid,
    input  hit,
    input  fsm_state
  );
endinterface

// File: rtl/target_load_ctrl.sv
// -----------------------------------------------------------------------------
// target_load_ctrl
//   Accepts a compact difficulty word (nBits: [31:24] exponent E,
//   [23:0] mantissa M), rejects malformed words, expands valid ones into a
//   256-bit target with a byte-shift datapath and publishes the result
//   atomically. In parallel it compares incoming hashes against the target
//   that is currently committed.
//
// Parameters:
//   SHIFT_BYTES - bytes shifted left per SHIFT cycle (1, 2 or 4)
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous reset, active low (0 = reset)
//   bus  - target_load_ctrl_if.slave:
//            bits_valid/bits_ready/bits : compact-word handshake
//            busy                       : expansion in progress
//            target/target_valid        : committed target, and whether one
//                                         has been committed since reset
//            target_update              : 1-cycle pulse when target changes
//            err_invalid                : 1-cycle pulse on a rejected word
//            hash_valid/hash            : hash offered for comparison
//            hit_valid/hit              : result one cycle later, hit=hash<=target
//            fsm_state                  : FSM state debug view
//
// Expansion timing (accept on edge 0): LOAD on edge 1, then
// ceil(max(E-3,0)/SHIFT_BYTES) SHIFT edges, then the COMMIT edge writes the
// target. The working register is separate from the published target, so no
// intermediate value is ever visible on the target port.
// -----------------------------------------------------------------------------
module target_load_ctrl #(
  parameter int SHIFT_BYTES = 1
) (
  input  logic             clk,
  input  logic             rst,
  target_load_ctrl_if.slave bus
);

  // Per-cycle shift step in bytes, in the width of the byte counter.
  // Only 1, 2 and 4 are meaningful step sizes.
  localparam logic [7:0] STEP = 8'(SHIFT_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  state_t       state_q,   state_d;
  logic [7:0]   e_q,       e_d;
  logic [23:0]  m_q,       m_d;
  logic [255:0] work_q,    work_d;
  logic [7:0]   cnt_q,     cnt_d;
  logic [255:0] target_q,  target_d;
  logic         tvalid_q,  tvalid_d;
  logic         update_q,  update_d;
  logic         err_q,     err_d;
  logic         hit_vld_q, hit_vld_d;
  logic         hit_q,     hit_d;

  // Word-check and datapath helpers
  logic         word_bad;
  logic [23:0]  m_small;   // mantissa right-justified for E < 3
  logic [7:0]   load_cnt;  // remaining byte shifts computed in LOAD
  logic [7:0]   step;      // bytes shifted this SHIFT cycle
  logic         accept;

  // A mantissa with its sign bit set, a zero mantissa or an exponent that
  // would push bits beyond 256 are all rejected.
  assign word_bad = bus.bits[23] || (bus.bits[23:0] == 24'd0) ||
                    (bus.bits[31:24] > 8'd32);

  // bits_ready is purely state-based so it never combinationally depends on
  // bits_valid.
  assign accept = (state_q == ST_IDLE) && bus.bits_valid;

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    e_d       = e_q;
    m_d       = m_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    tvalid_d  = tvalid_q;
    update_d  = 1'b0;
    err_d     = 1'b0;
    m_small   = 24'd0;
    load_cnt  = 8'd0;
    step      = 8'd0;

    // Comparator runs every cycle against the registered (committed) target,
    // so a hash that lands on the COMMIT edge still sees the old target.
    hit_vld_d = bus.hash_valid && tvalid_q;
    hit_d     = bus.hash_valid && tvalid_q && (bus.hash <= target_q);

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (word_bad) begin
            err_d = 1'b1;
          end else begin
            e_d     = bus.bits[31:24];
            m_d     = bus.bits[23:0];
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (e_q >= 8'd3) begin
          work_d   = {232'd0, m_q};
          load_cnt = e_q - 8'd3;
        end else begin
          // E < 3: the value is M shifted right by whole bytes; E = 0 drops
          // all three mantissa bytes.
          case (e_q[1:0])
            2'd2:    m_small = {8'd0,  m_q[23:8]};
            2'd1:    m_small = {16'd0, m_q[23:16]};
            default: m_small = 24'd0;
          endcase
          work_d   = {232'd0, m_small};
          load_cnt = 8'd0;
        end
        cnt_d   = load_cnt;
        state_d = (load_cnt != 8'd0) ? ST_SHIFT : ST_COMMIT;
      end

      ST_SHIFT: begin
        step    = (cnt_q < STEP) ? cnt_q : STEP;
        work_d  = work_q << {step, 3'b000};
        cnt_d   = cnt_q - step;
        if (cnt_d == 8'd0) begin
          state_d = ST_COMMIT;
        end
      end

      ST_COMMIT: begin
        target_d = work_q;
        tvalid_d = 1'b1;
        update_d = 1'b1;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers; reset also wipes the committed target.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      e_q       <= 8'd0;
      m_q       <= 24'd0;
      work_q    <= 256'd0;
      cnt_q     <= 8'd0;
      target_q  <= 256'd0;
      tvalid_q  <= 1'b0;
      update_q  <= 1'b0;
      err_q     <= 1'b0;
      hit_vld_q <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      e_q       <= e_d;
      m_q       <= m_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      tvalid_q  <= tvalid_d;
      update_q  <= update_d;
      err_q     <= err_d;
      hit_vld_q <= hit_vld_d;
      hit_q     <= hit_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.bits_ready    = (state_q == ST_IDLE);
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.target        = target_q;
  assign bus.target_valid  = tvalid_q;
  assign bus.target_update = update_q;
  assign bus.err_invalid   = err_q;
  assign bus.hit_valid     = hit_vld_q;
  assign bus.hit           = hit_q;
  assign bus.fsm_state     = state_q;

endmodule

// File: tb/tb_target_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_target_load_ctrl
//   Directed bench for target_load_ctrl. A table of compact words with
//   hand-computed targets and commit latencies is applied to an instance with
//   SHIFT_BYTES=1; a second instance with SHIFT_BYTES=4 checks the shorter
//   latency. Hand-written sequences cover the hash comparator, a hash arriving
//   on the COMMIT edge, and a reset in the middle of the SHIFT phase.
// -----------------------------------------------------------------------------
module tb_target_load_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  target_load_ctrl_if if1 ();
  target_load_ctrl_if if4 ();

  target_load_ctrl #(.SHIFT_BYTES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  target_load_ctrl #(.SHIFT_BYTES(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  // Sampled views indexed by instance (0 -> SHIFT_BYTES=1, 1 -> SHIFT_BYTES=4)
  logic [1:0]   upd_w, err_w, rdy_w, tv_w, busy_w;
  logic [255:0] tgt_w [2];
  assign upd_w    = {if4.target_update, if1.target_update};
  assign err_w    = {if4.err_invalid,   if1.err_invalid};
  assign rdy_w    = {if4.bits_ready,    if1.bits_ready};
  assign tv_w     = {if4.target_valid,  if1.target_valid};
  assign busy_w   = {if4.busy,          if1.busy};
  assign tgt_w[0] = if1.target;
  assign tgt_w[1] = if4.target;

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_bits(input int sel, input logic v, input logic [31:0] w);
    if (sel == 0) begin
      if1.bits_valid = v;
      if1.bits       = w;
    end else begin
      if4.bits_valid = v;
      if4.bits       = w;
    end
  endtask

  // Offers one word, waits for either target_update or err_invalid.
  // lat    : edge index (accept edge = 0) after which the pulse was seen, -1 on timeout
  // hi_cnt : number of post-edge samples with bits_ready=1 before the pulse
  // rdy_pre: bits_ready just before the accept edge
  task automatic send_word(input int sel, input logic [31:0] w,
                           output int lat, output logic err,
                           output int hi_cnt, output logic rdy_pre);
    lat    = -1;
    err    = 1'b0;
    hi_cnt = 0;
    @(negedge clk);
    rdy_pre = rdy_w[sel];
    drive_bits(sel, 1'b1, w);
    @(posedge clk);
    #1;
    drive_bits(sel, 1'b0, 32'd0);
    for (int n = 0; n <= 60; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (upd_w[sel]) begin
        lat = n;
        break;
      end
      if (err_w[sel]) begin
        err = 1'b1;
        lat = n;
        break;
      end
      if (rdy_w[sel]) hi_cnt++;
    end
  endtask

  task automatic hash_check(input string nm, input logic [255:0] h, input logic exp_hit);
    @(negedge clk);
    if1.hash_valid = 1'b1;
    if1.hash       = h;
    @(posedge clk);
    #1;
    chk({nm, "_hv"},  if1.hit_valid, 1'b1);
    chk({nm, "_hit"}, if1.hit,       exp_hit);
    @(negedge clk);
    if1.hash_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, "_hv_drop"}, if1.hit_valid, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0]  word;
    logic         exp_err;
    int           exp_lat;
    logic [255:0] exp_tgt;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  localparam logic [255:0] T_1D = 256'hFFFF << 208;

  initial begin
    int          lat;
    int          hi_cnt;
    logic        err;
    logic        rdy_pre;
    logic        partial_bad;
    logic [255:0] t_plus;

    vecs[0]  = '{32'h1d00ffff, 1'b0, 28, T_1D};
    vecs[1]  = '{32'h03123456, 1'b0, 2,  256'h123456};
    vecs[2]  = '{32'h02123456, 1'b0, 2,  256'h1234};
    vecs[3]  = '{32'h01123456, 1'b0, 2,  256'h12};
    vecs[4]  = '{32'h1d800000, 1'b1, 0,  256'h12};
    vecs[5]  = '{32'h21000001, 1'b1, 0,  256'h12};
    vecs[6]  = '{32'h1d000000, 1'b1, 0,  256'h12};
    vecs[7]  = '{32'h04123456, 1'b0, 3,  256'h12345600};
    vecs[8]  = '{32'h00123456, 1'b0, 2,  256'h0};
    vecs[9]  = '{32'h20000001, 1'b0, 31, 256'h1 << 232};
    vecs[10] = '{32'h1d00ffff, 1'b0, 28, T_1D};

    if1.bits_valid = 1'b0; if1.bits = 32'd0; if1.hash_valid = 1'b0; if1.hash = 256'd0;
    if4.bits_valid = 1'b0; if4.bits = 32'd0; if4.hash_valid = 1'b0; if4.hash = 256'd0;

    // ---- reset ----
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_target",  if1.target,        256'd0);
    chk("rst_tvalid",  if1.target_valid,  1'b0);
    chk("rst_update",  if1.target_update, 1'b0);
    chk("rst_err",     if1.err_invalid,   1'b0);
    chk("rst_hitv",    if1.hit_valid,     1'b0);
    chk("rst_hit",     if1.hit,           1'b0);
    chk("rst_busy",    if1.busy,          1'b0);
    chk("rst_ready",   if1.bits_ready,    1'b1);
    chk("rst_state",   if1.fsm_state,     2'd0);
    @(negedge clk);
    rst = 1'b1;

    // ---- hash before any target: no result ----
    @(negedge clk);
    if1.hash_valid = 1'b1;
    if1.hash       = 256'd0;
    @(posedge clk);
    #1;
    chk("notgt_hitv", if1.hit_valid, 1'b0);
    chk("notgt_hit",  if1.hit,       1'b0);
    @(negedge clk);
    if1.hash_valid = 1'b0;

    // ---- table-driven expansion vectors (SHIFT_BYTES=1) ----
    for (int i = 0; i < NV; i++) begin
      send_word(0, vecs[i].word, lat, err, hi_cnt, rdy_pre);
      chk($sformatf("v%0d_ready_pre", i), rdy_pre,      1'b1);
      chk($sformatf("v%0d_err", i),       err,          vecs[i].exp_err);
      chk($sformatf("v%0d_lat", i),       lat,          vecs[i].exp_lat);
      chk($sformatf("v%0d_busy_rdy", i),  hi_cnt,       0);
      chk($sformatf("v%0d_target", i),    if1.target,   vecs[i].exp_tgt);
      chk($sformatf("v%0d_tvalid", i),    if1.target_valid, 1'b1);
      chk($sformatf("v%0d_ready_post", i), if1.bits_ready, 1'b1);
      // Pulses must be single-cycle and the block idle afterwards
      for (int k = 0; k < 2; k++) begin
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_idle%0d_upd", i, k),  if1.target_update, 1'b0);
        chk($sformatf("v%0d_idle%0d_err", i, k),  if1.err_invalid,   1'b0);
        chk($sformatf("v%0d_idle%0d_busy", i, k), if1.busy,          1'b0);
      end
      chk($sformatf("v%0d_target_hold", i), if1.target, vecs[i].exp_tgt);
    end

    // ---- SHIFT_BYTES=4 latency ----
    send_word(1, 32'h1d00ffff, lat, err, hi_cnt, rdy_pre);
    chk("sb4_err",    err,        1'b0);
    chk("sb4_lat",    lat,        9);
    chk("sb4_rdy",    hi_cnt,     0);
    chk("sb4_target", tgt_w[1],   T_1D);
    chk("sb4_tvalid", tv_w[1],    1'b1);
    chk("sb4_busy",   busy_w[1],  1'b0);

    // ---- comparator against committed 0x1d00ffff target ----
    t_plus = T_1D + 256'd1;
    hash_check("hash_eq",    T_1D,               1'b1);
    hash_check("hash_plus1", t_plus,             1'b0);
    hash_check("hash_zero",  256'd0,             1'b1);
    hash_check("hash_minus", T_1D - 256'd1,      1'b1);
    hash_check("hash_max",   {256{1'b1}},        1'b0);

    // ---- hash on the COMMIT edge sees the old target ----
    @(negedge clk);
    drive_bits(0, 1'b1, 32'h03000001);
    if1.hash_valid = 1'b1;
    if1.hash       = T_1D;
    @(posedge clk);                      // edge 0: accept
    #1;
    drive_bits(0, 1'b0, 32'd0);
    @(posedge clk);                      // edge 1: LOAD
    #1;
    chk("ce_target_pre", if1.target, T_1D);
    @(posedge clk);                      // edge 2: COMMIT
    #1;
    chk("ce_update",  if1.target_update, 1'b1);
    chk("ce_target",  if1.target,        256'd1);
    chk("ce_hitv",    if1.hit_valid,     1'b1);
    chk("ce_hit_old", if1.hit,           1'b1);
    @(posedge clk);                      // edge 3: new target in force
    #1;
    chk("ce_hit_new", if1.hit,           1'b0);
    chk("ce_hitv2",   if1.hit_valid,     1'b1);
    @(negedge clk);
    if1.hash_valid = 1'b0;

    // ---- reset during the 10th SHIFT cycle ----
    @(negedge clk);
    drive_bits(0, 1'b1, 32'h1d00ffff);
    @(posedge clk);                      // edge 0: accept
    #1;
    drive_bits(0, 1'b0, 32'd0);
    partial_bad = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (if1.target !== 256'd1 || if1.target_update !== 1'b0) partial_bad = 1'b1;
    end
    chk("mid_no_partial", partial_bad,  1'b0);
    chk("mid_state",      if1.fsm_state, 2'd2);
    rst            = 1'b0;
    if1.hash_valid = 1'b1;
    if1.hash       = 256'd0;
    @(posedge clk);                      // edge 11: reset applied
    #1;
    chk("mr_target", if1.target,       256'd0);
    chk("mr_tvalid", if1.target_valid, 1'b0);
    chk("mr_ready",  if1.bits_ready,   1'b1);
    chk("mr_busy",   if1.busy,         1'b0);
    chk("mr_hitv",   if1.hit_valid,    1'b0);
    chk("mr_state",  if1.fsm_state,    2'd0);
    rst            = 1'b1;
    if1.hash_valid = 1'b0;
    send_word(0, 32'h03123456, lat, err, hi_cnt, rdy_pre);
    chk("after_rst_ready", rdy_pre,          1'b1);
    chk("after_rst_err",   err,              1'b0);
    chk("after_rst_lat",   lat,              2);
    chk("after_rst_tgt",   if1.target,       256'h123456);
    chk("after_rst_tv",    if1.target_valid, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Absolute bound on run time
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_vec);
    $fatal(1);
  end

endmodule

// File: doc/target_load_ctrl.md
Name: target_load_ctrl

Overview:
- Sequencer between the block-header source and the hash-check stage of the miner.
- Accepts a compact 32-bit difficulty word (nBits) through a valid/ready handshake, checks it, and expands it into a 256-bit target using a multi-cycle byte-shift datapath.
- Publishes the target atomically to the comparator and uses the currently committed target to answer hash-vs-target queries from the hashing cores.

Parameters:
SHIFT_BYTES, 1, bytes shifted left per SHIFT cycle; legal values 1, 2, 4.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-low reset (0 = reset)
bits_valid  input  1  compact word offered
bits_ready  output  1  block can accept a compact word
bits  input  32  compact word: [31:24] exponent E, [23:0] mantissa M
busy  output  1  expansion in progress
target  output  256  committed expanded target
target_valid  output  1  at least one target has been committed since reset
target_update  output  1  one-cycle pulse on the cycle target changes
err_invalid  output  1  one-cycle pulse when a compact word is rejected
hash_valid  input  1  hash offered for comparison
hash  input  256  hash value, unsigned
hit_valid  output  1  comparison result valid
hit  output  1  1 when hash <= target

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst.
- Reset values: state IDLE, target=0, target_valid=0, target_update=0, err_invalid=0, hit_valid=0, hit=0, busy=0, bits_ready=1.
- Handshake:
  - Accept happens on a rising edge with bits_valid && bits_ready.
  - bits_ready = (state==IDLE). busy = (state!=IDLE).
  - Upstream holds bits while bits_ready=0. Nothing is dropped.
- Validity check at accept:
  - A word is invalid if M[23]==1, M==0, or E>32.
  - Invalid: err_invalid pulses on the next cycle, state stays IDLE, target and target_valid are unchanged.
- State IDLE: on a valid accept, latch E and M, go to LOAD.
- State LOAD (1 cycle):
  - E>=3: work=M zero-extended to 256 bits, cnt=E-3.
  - E<3: work=M>>(8*(3-E)), cnt=0.
  - Next state: SHIFT if cnt!=0, else COMMIT.
- State SHIFT:
  - Each cycle, s=min(cnt,SHIFT_BYTES); work<<=8*s; cnt-=s.
  - Go to COMMIT once cnt reaches 0.
- State COMMIT (1 cycle): target<=work, target_valid<=1, target_update pulses, return to IDLE.
- Latency: with accept on edge 0, target changes on edge 2+ceil(max(E-3,0)/SHIFT_BYTES). The next word can be accepted on the edge after COMMIT.
- No partial target is ever visible on the target port.
- Comparator (1-cycle pipeline, independent of the FSM):
  - hit_valid <= hash_valid && target_valid.
  - hit <= hash_valid && target_valid && (hash <= target), unsigned 256-bit compare.
  - hash_valid while target_valid==0: hit_valid=0, hit=0.
  - While busy, hashes are compared against the previously committed target.
  - COMMIT and hash_valid on the same edge: that hash is compared against the old target.
- Reset mid-operation: rst=0 during any state aborts expansion and returns all outputs to reset values on that edge. The committed target is cleared.

Test Plan:
- 0x1d00ffff accepted on edge 0, SHIFT_BYTES=1 -> target=0xFFFF<<208 (0x00000000FFFF0000...00), target_update on edge 28, bits_ready=0 on edges 1..28, target_valid=1 afterwards.
- 0x03123456 -> target=0x123456, update on edge 2. Then 0x02123456 -> target=0x1234. 0x01123456 -> target=0x12. Repeat 0x1d00ffff with SHIFT_BYTES=4 -> update on edge 9.
- Invalid words 0x1d800000, 0x21000001 and 0x1d000000 -> one err_invalid pulse each, target unchanged, no target_update, bits_ready stays 1.
- Target 0x1d00ffff committed; hash=target -> hit=1. hash=target+1 -> hit=0. hash=0 -> hit=1. hit_valid follows hash_valid by one cycle.
- Load 0x03000001 while hashes stream in; hash=0xFFFF<<208 presented on the COMMIT edge -> hit=1 (old target); same hash on the next cycle -> hit=0.
- rst=0 for one cycle in the 10th SHIFT cycle -> target=0, target_valid=0, bits_ready=1, hit_valid=0. The following 0x03123456 completes normally.
